// File: rtl/rp_queue_sequencer.sv
// rp_queue_sequencer: round-robin NVMe queue-pair TLP test sequencer for the root port.
// Define RP_SEQ_CPL_TIMEOUT_EN to add the read-completion timeout counter.
module rp_queue_sequencer #(
  parameter int          NUM_Q       = 2,
  parameter int          Q_DEPTH     = 16,
  parameter logic [63:0] BAR_BASE    = 64'h0000_0010_0000_0004,
  parameter int          DB_STRIDE   = 4,
  parameter int          ITERATIONS  = 4096,
  parameter int          CPL_TIMEOUT = 1024
) (
  input  logic         user_clk,
  input  logic         reset_n,
  input  logic         user_lnk_up,
  output logic         start_config,
  input  logic         finished_config,
  input  logic         failed_config,
  output logic [2:0]   tx_type,
  output logic [7:0]   tx_tag,
  output logic [63:0]  tx_addr,
  output logic [127:0] tx_data,
  output logic [10:0]  tx_length,
  output logic         tx_start,
  input  logic         tx_done,
  output logic         rx_type,
  output logic [7:0]   rx_tag,
  output logic [31:0]  rx_data,
  input  logic         rx_success,
  input  logic         rx_fail,
  input  logic [2:0]   addr_offset,
  input  logic [10:0]  vio_length,
  output logic [3:0]   ctl_state,
  output logic [2:0]   q_idx,
  output logic         test_done,
  output logic [15:0]  pass_count,
  output logic [15:0]  err_count
);
  localparam int QW = $clog2(Q_DEPTH);
  localparam logic [127:0] WR_DATA = 128'h1234_5678_90ab_cdef_1234_5678_90ab_cdef;
  typedef enum logic [3:0] {
    WAIT_CFG = 4'd0, DWR = 4'd1, DWR_W = 4'd2, SQDB = 4'd3, SQDB_W = 4'd4,
    DRD = 4'd5, DRD_W = 4'd6, CPL_W = 4'd7, CQDB = 4'd8, CQDB_W = 4'd9,
    NEXT = 4'd10, ERROR = 4'd11, TESTDONE = 4'd12
  } state_t;
  state_t        state;
  logic          lnk_q, lnk_q2, cfg_fail, issue, data_tlp;
  logic [31:0]   iter, nxt_iter;
  logic [QW-1:0] tail [8];
  logic [QW-1:0] head [8];
  logic [QW-1:0] nt, nh;
  logic [63:0]   tlp_addr;
`ifdef RP_SEQ_CPL_TIMEOUT_EN
  logic [31:0]   tmo;
`endif
  assign ctl_state = state;
  // Doorbells: SQ tail at even slot 2q, CQ head at odd slot 2q+1
  always_comb begin
    data_tlp = state == DWR || state == DRD;
    issue = user_lnk_up && (data_tlp || state == SQDB || state == CQDB);
    nt = tail[q_idx] + QW'(1);
    nh = head[q_idx] + QW'(1);
    nxt_iter = iter + 32'(q_idx == 3'(NUM_Q - 1));
    tlp_addr = data_tlp ? BAR_BASE + {59'd0, addr_offset, 2'b00}
                        : BAR_BASE + 64'h1000 + {60'd0, q_idx, state == CQDB} * 64'(DB_STRIDE);
  end
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      lnk_q <= 1'b0;
      lnk_q2 <= 1'b0;
      start_config <= 1'b0;
      state <= WAIT_CFG;
      cfg_fail <= 1'b0;
      iter <= '0;
      q_idx <= '0;
      test_done <= 1'b0;
      pass_count <= '0;
      err_count <= '0;
      tx_type <= '0;
      tx_tag <= '0;
      tx_addr <= '0;
      tx_data <= '0;
      tx_length <= '0;
      tx_start <= 1'b0;
      rx_type <= 1'b0;
      rx_tag <= '0;
      rx_data <= '0;
`ifdef RP_SEQ_CPL_TIMEOUT_EN
      tmo <= '0;
`endif
      for (int i = 0; i < 8; i++) begin
        tail[i] <= '0;
        head[i] <= '0;
      end
    end else begin
      lnk_q <= user_lnk_up;
      lnk_q2 <= lnk_q;
      start_config <= lnk_q & ~lnk_q2;
      tx_start <= 1'b0;
      if (issue) begin
        tx_type <= state == DRD ? 3'b000 : 3'b001;
        tx_tag <= tx_tag + 8'd1;
        rx_tag <= tx_tag + 8'd1;
        tx_addr <= tlp_addr;
        tx_data <= state == SQDB ? 128'(nt) : state == CQDB ? 128'(nh) : WR_DATA;
        tx_length <= data_tlp ? vio_length : 11'd1;
        tx_start <= 1'b1;
      end
      if (!user_lnk_up) begin
        state <= WAIT_CFG;
        cfg_fail <= 1'b0;
        iter <= '0;
        q_idx <= '0;
        test_done <= 1'b0;
        pass_count <= '0;
        err_count <= '0;
        for (int i = 0; i < 8; i++) begin
          tail[i] <= '0;
          head[i] <= '0;
        end
      end else begin
        case (state)
          WAIT_CFG: begin
            if (failed_config) begin
              cfg_fail <= 1'b1;
              state <= ERROR;
            end else if (finished_config) state <= DWR;
          end
          DWR: state <= DWR_W;
          DWR_W: if (tx_done) state <= SQDB;
          SQDB: begin
            tail[q_idx] <= nt;
            state <= SQDB_W;
          end
          SQDB_W: if (tx_done) state <= DRD;
          DRD: begin
            rx_type <= 1'b1;
            rx_data <= 32'h1234_5678;
            state <= DRD_W;
          end
          DRD_W: begin
            if (tx_done) state <= CPL_W;
`ifdef RP_SEQ_CPL_TIMEOUT_EN
            tmo <= '0;
`endif
          end
          CPL_W: begin
            if (rx_fail) state <= ERROR;
            else if (rx_success) begin
              pass_count <= pass_count + 16'(pass_count != 16'hFFFF);
              state <= CQDB;
            end
`ifdef RP_SEQ_CPL_TIMEOUT_EN
            else if (tmo == 32'(CPL_TIMEOUT - 1)) state <= ERROR;
            else tmo <= tmo + 32'd1;
`endif
          end
          CQDB: begin
            head[q_idx] <= nh;
            state <= CQDB_W;
          end
          CQDB_W: if (tx_done) state <= NEXT;
          ERROR: begin
            err_count <= err_count + 16'(err_count != 16'hFFFF);
            state <= cfg_fail ? TESTDONE : NEXT;
          end
          NEXT: begin
            q_idx <= q_idx == 3'(NUM_Q - 1) ? 3'd0 : q_idx + 3'd1;
            iter <= nxt_iter;
            test_done <= nxt_iter == 32'(ITERATIONS);
            state <= nxt_iter == 32'(ITERATIONS) ? TESTDONE : DWR;
          end
          default: state <= state;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rp_queue_sequencer.sv
// tb_rp_queue_sequencer: directed table-driven bench for rp_queue_sequencer.
module tb_rp_queue_sequencer;
  logic         user_clk = 1'b0, reset_n = 1'b0, user_lnk_up = 1'b0;
  logic         finished_config = 1'b0, failed_config = 1'b0;
  logic         tx_done = 1'b0, rx_success = 1'b0, rx_fail = 1'b0;
  logic [2:0]   addr_offset = 3'd2;
  logic [10:0]  vio_length = 11'd4;
  logic         start_config, tx_start, rx_type, test_done;
  logic [2:0]   tx_type, q_idx;
  logic [7:0]   tx_tag, rx_tag;
  logic [63:0]  tx_addr;
  logic [127:0] tx_data;
  logic [10:0]  tx_length;
  logic [31:0]  rx_data;
  logic [3:0]   ctl_state;
  logic [15:0]  pass_count, err_count;

  localparam logic [127:0] PAY = 128'h1234_5678_90ab_cdef_1234_5678_90ab_cdef;
  typedef struct {
    logic [2:0] typ; logic [7:0] tag; logic [7:0] rtag;
    logic [63:0] addr; logic [127:0] data; logic [10:0] len;
  } tlp_t;
  typedef struct {
    logic [2:0] typ; logic [63:0] addr; logic [127:0] data; logic [10:0] len; bit has_data;
  } vec_t;

  tlp_t cap[$];
  int   vec_cnt = 0, miss_cnt = 0, done_cnt = 0;
  bit   auto_cpl = 1'b0;

  rp_queue_sequencer #(.NUM_Q(2), .Q_DEPTH(4), .ITERATIONS(40), .CPL_TIMEOUT(8)) dut (
    .user_clk(user_clk), .reset_n(reset_n), .user_lnk_up(user_lnk_up),
    .start_config(start_config), .finished_config(finished_config), .failed_config(failed_config),
    .tx_type(tx_type), .tx_tag(tx_tag), .tx_addr(tx_addr), .tx_data(tx_data),
    .tx_length(tx_length), .tx_start(tx_start), .tx_done(tx_done),
    .rx_type(rx_type), .rx_tag(rx_tag), .rx_data(rx_data),
    .rx_success(rx_success), .rx_fail(rx_fail),
    .addr_offset(addr_offset), .vio_length(vio_length),
    .ctl_state(ctl_state), .q_idx(q_idx), .test_done(test_done),
    .pass_count(pass_count), .err_count(err_count)
  );

  always #5 user_clk = ~user_clk;

  // Generator/checker model: log each TLP, answer tx_done 3 cycles later, optionally complete reads
  initial forever begin
    tlp_t t;
    @(negedge user_clk);
    tx_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      tx_done = done_cnt == 0;
    end
    if (tx_start) begin
      t.typ = tx_type; t.tag = tx_tag; t.rtag = rx_tag;
      t.addr = tx_addr; t.data = tx_data; t.len = tx_length;
      cap.push_back(t);
      done_cnt = 3;
    end
    if (auto_cpl) rx_success = ctl_state == 4'd7 && !rx_success;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_state(input logic [3:0] s, input int lim, input string name);
    int n = 0;
    while (ctl_state !== s && n < lim) begin
      @(negedge user_clk);
      n++;
    end
    if (ctl_state !== s) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL %s: state %0d not reached within %0d cycles", name, s, lim);
    end
  endtask

  task automatic wait_cap(input int cnt, input int lim, input string name);
    int n = 0;
    while (cap.size() < cnt && n < lim) begin
      @(negedge user_clk);
      n++;
    end
    if (cap.size() < cnt) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL %s: %0d TLPs seen, %0d needed within %0d cycles", name, cap.size(), cnt, lim);
    end
  endtask

  initial begin
    vec_t tbl[8];
    int   tag_bad;
    tbl[0] = '{3'd1, 64'h10_0000_000C, PAY,      11'd4, 1'b1};
    tbl[1] = '{3'd1, 64'h10_0000_1004, 128'd1,   11'd1, 1'b1};
    tbl[2] = '{3'd0, 64'h10_0000_000C, 128'd0,   11'd4, 1'b0};
    tbl[3] = '{3'd1, 64'h10_0000_1008, 128'd1,   11'd1, 1'b1};
    tbl[4] = '{3'd1, 64'h10_0000_000C, PAY,      11'd4, 1'b1};
    tbl[5] = '{3'd1, 64'h10_0000_100C, 128'd1,   11'd1, 1'b1};
    tbl[6] = '{3'd0, 64'h10_0000_000C, 128'd0,   11'd4, 1'b0};
    tbl[7] = '{3'd1, 64'h10_0000_1010, 128'd1,   11'd1, 1'b1};

    repeat (3) @(posedge user_clk);
    #1;
    chk("rst_state", ctl_state, 0);
    chk("rst_start_config", start_config, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_tag", tx_tag, 0);
    chk("rst_tx_addr", tx_addr, 0);
    chk("rst_q_idx", q_idx, 0);
    chk("rst_test_done", test_done, 0);
    chk("rst_counts", {pass_count, err_count}, 0);

    @(negedge user_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge user_clk);
    user_lnk_up = 1'b1;
    @(posedge user_clk); #1 chk("start_cfg_c1", start_config, 0);
    @(posedge user_clk); #1 chk("start_cfg_c2", start_config, 1);
    @(posedge user_clk); #1 chk("start_cfg_c3", start_config, 0);

    @(negedge user_clk);
    auto_cpl = 1'b1;
    finished_config = 1'b1;
    @(negedge user_clk);
    finished_config = 1'b0;
    wait_cap(8, 400, "startup");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("v%0d_type", i), cap[i].typ, tbl[i].typ);
      chk($sformatf("v%0d_addr", i), cap[i].addr, tbl[i].addr);
      chk($sformatf("v%0d_len", i), cap[i].len, tbl[i].len);
      chk($sformatf("v%0d_tag", i), cap[i].tag, 8'(i + 1));
      chk($sformatf("v%0d_rx_tag", i), cap[i].rtag, 8'(i + 1));
      if (tbl[i].has_data) chk($sformatf("v%0d_data", i), cap[i].data, tbl[i].data);
    end
    chk("rx_type", rx_type, 1);
    chk("rx_data", rx_data, 32'h1234_5678);

    wait_cap(320, 9000, "all_tlps");
    chk("sq0_pass4_wrap", cap[25].data, 0);
    chk("sq0_pass5", cap[33].data, 1);
    chk("sq1_pass5", cap[37].data, 1);
    chk("tag_ff", cap[254].tag, 8'hFF);
    chk("tag_wrap_00", cap[255].tag, 8'h00);
    tag_bad = 0;
    for (int i = 0; i < cap.size(); i++) if (cap[i].tag !== 8'(i + 1)) tag_bad++;
    chk("tag_sequence", tag_bad, 0);
    wait_state(4'd12, 200, "test_done_state");
    chk("test_done", test_done, 1);
    chk("pass_count_done", pass_count, 80);
    chk("err_count_done", err_count, 0);
    chk("q_idx_done", q_idx, 0);
    repeat (10) @(negedge user_clk);
    chk("no_tlp_after_done", cap.size(), 320);

    user_lnk_up = 1'b0;
    @(posedge user_clk); #1;
    chk("drop_state", ctl_state, 0);
    chk("drop_test_done", test_done, 0);
    chk("drop_pass", pass_count, 0);
    repeat (5) @(negedge user_clk);
    cap.delete();
    auto_cpl = 1'b0;
    rx_success = 1'b0;
    user_lnk_up = 1'b1;
    finished_config = 1'b1;
    @(negedge user_clk);
    finished_config = 1'b0;
    wait_state(4'd7, 200, "cpl_w_q0");
    rx_success = 1'b1;
    rx_fail = 1'b1;
    @(posedge user_clk); #1 chk("fail_prio_state", ctl_state, 11);
    rx_success = 1'b0;
    rx_fail = 1'b0;
    @(posedge user_clk); #1;
    chk("fail_next_state", ctl_state, 10);
    chk("fail_err_count", err_count, 1);
    chk("fail_pass_count", pass_count, 0);
    @(posedge user_clk); #1;
    chk("fail_cont_state", ctl_state, 1);
    chk("fail_cont_q", q_idx, 1);
    chk("relink_sq_addr", cap[1].addr, 64'h10_0000_1004);
    chk("relink_sq_tail", cap[1].data, 1);

    wait_state(4'd7, 200, "cpl_w_q1");
`ifdef RP_SEQ_CPL_TIMEOUT_EN
    repeat (7) @(posedge user_clk);
    #1 chk("tmo_before", ctl_state, 7);
    @(posedge user_clk); #1 chk("tmo_error", ctl_state, 11);
    @(posedge user_clk); #1 chk("tmo_err_count", err_count, 2);
    wait_state(4'd7, 200, "cpl_w_again");
`else
    repeat (40) @(posedge user_clk);
    #1 chk("no_tmo_hold", ctl_state, 7);
    chk("no_tmo_err", err_count, 1);
`endif

    @(negedge user_clk);
    user_lnk_up = 1'b0;
    @(posedge user_clk); #1;
    chk("drop_cplw_state", ctl_state, 0);
    chk("drop_cplw_err", err_count, 0);
    chk("drop_cplw_q", q_idx, 0);
    repeat (5) @(negedge user_clk);
    cap.delete();
    auto_cpl = 1'b1;
    user_lnk_up = 1'b1;
    finished_config = 1'b1;
    @(negedge user_clk);
    finished_config = 1'b0;
    wait_cap(2, 100, "restart");
    chk("restart_sq_addr", cap[1].addr, 64'h10_0000_1004);
    chk("restart_sq_tail", cap[1].data, 1);

    repeat (3) @(negedge user_clk);
    user_lnk_up = 1'b0;
    repeat (5) @(negedge user_clk);
    cap.delete();
    user_lnk_up = 1'b1;
    failed_config = 1'b1;
    @(posedge user_clk); #1 chk("cfg_fail_error", ctl_state, 11);
    failed_config = 1'b0;
    @(posedge user_clk); #1;
    chk("cfg_fail_done", ctl_state, 12);
    chk("cfg_fail_err", err_count, 1);
    repeat (20) @(negedge user_clk);
    chk("cfg_fail_no_tlp", cap.size(), 0);
    chk("cfg_fail_terminal", ctl_state, 12);
    chk("cfg_fail_test_done", test_done, 0);

    user_lnk_up = 1'b0;
    repeat (5) @(negedge user_clk);
    cap.delete();
    user_lnk_up = 1'b1;
    finished_config = 1'b1;
    @(negedge user_clk);
    finished_config = 1'b0;
    wait_cap(3, 100, "pre_reset");
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_state", ctl_state, 0);
    chk("async_rst_tag", tx_tag, 0);
    chk("async_rst_addr", tx_addr, 0);
    chk("async_rst_len", tx_length, 0);
    chk("async_rst_rx_data", rx_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
